// File: rtl/muldiv_if.sv
// Core-side bundle for the multiply/divide unit: launch, HI/LO moves,
// status and the architectural HI/LO values.
interface muldiv_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [5:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             wr_hi;
    logic             wr_lo;
    logic             busy;
    logic             stall;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, wr_hi, wr_lo,
        input  busy, stall, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, wr_hi, wr_lo,
        output busy, stall, done, hi, lo
    );
endinterface

// File: rtl/muldiv_seq.sv
// Sequential MULTU/DIVU unit with HI/LO registers: one bit per cycle,
// shift-add multiply and restoring divide sharing one 2*WIDTH accumulator.
module muldiv_seq #(
    parameter int unsigned WIDTH    = 32,
    parameter logic [5:0]  OP_MULTU = 6'h19,
    parameter logic [5:0]  OP_DIVU  = 6'h1B
) (
    input  logic     clk,
    input  logic     rst,
    muldiv_if.slave  bus
);
    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned ACC_W = 2 * WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] opnd;
    logic [ACC_W-1:0] acc;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             busy_q;
    logic             done_q;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_rem;
    logic [WIDTH:0]   div_diff;
    logic             div_ge;
    logic [ACC_W-1:0] mul_next;
    logic [ACC_W-1:0] div_next;
    logic [ACC_W-1:0] step_next;
    logic             idle_like;
    logic             accept_mul;
    logic             accept_div;
    logic             last_iter;

    // Multiply: acc = {partial hi, multiplier}, shifted right each step.
    // Divide:   acc = {remainder, dividend/quotient}, shifted left each step.
    always_comb begin
        mul_sum   = {1'b0, acc[ACC_W-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
        mul_next  = {mul_sum, acc[WIDTH-1:1]};
        div_rem   = {acc[ACC_W-1:WIDTH], acc[WIDTH-1]};
        div_diff  = div_rem - {1'b0, opnd};
        div_ge    = (div_rem >= {1'b0, opnd});
        div_next  = {(div_ge ? div_diff[WIDTH-1:0] : div_rem[WIDTH-1:0]),
                     acc[WIDTH-2:0], div_ge};
        step_next = (state == DIV) ? div_next : mul_next;
    end

    assign idle_like  = (state == IDLE) || (state == DONE);
    assign accept_mul = idle_like && bus.start && (bus.op == OP_MULTU);
    assign accept_div = idle_like && bus.start && (bus.op == OP_DIVU);
    assign last_iter  = (cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            cnt    <= '0;
            opnd   <= '0;
            acc    <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (accept_mul) begin
                        state  <= MUL;
                        acc    <= {{WIDTH{1'b0}}, bus.b};
                        opnd   <= bus.a;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                    end else if (accept_div) begin
                        state  <= DIV;
                        acc    <= {{WIDTH{1'b0}}, bus.a};
                        opnd   <= bus.b;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                    end else begin
                        // An accepted start drops any coincident HI/LO move.
                        state <= IDLE;
                        if (bus.wr_hi) hi_q <= bus.a;
                        if (bus.wr_lo) lo_q <= bus.a;
                    end
                end
                MUL, DIV: begin
                    acc <= step_next;
                    if (last_iter) begin
                        hi_q   <= step_next[ACC_W-1:WIDTH];
                        lo_q   <= step_next[WIDTH-1:0];
                        state  <= DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        cnt    <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy  = busy_q;
    assign bus.stall = busy_q;
    assign bus.done  = done_q;
    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;
endmodule
